// File: rtl/uart_pkg.sv
// Shared UART types and helpers for the transmitter, the bench and a future receiver.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;

  localparam bit PARITY_EVEN = 1'b0;
  localparam bit PARITY_ODD  = 1'b1;

  // Clock cycles occupied by one frame, start bit through last stop bit.
  function automatic int frame_cycles(input int dw, input int cpb, input int par, input int stop);
    return cpb * (1 + dw + par + stop);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-time divider: counts 0..CLKS_PER_BIT-1, pulses bit_done on the last count.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  output logic bit_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 cnt <= '0;
    else if (clr || cnt == LAST)  cnt <= '0;
    else                          cnt <= cnt + CW'(1);
  end

  assign bit_done = (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: pops words via valid/grant and sends start, data LSB-first,
// optional parity and stop bits at a fixed CLKS_PER_BIT rate.
module uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  in_grant_o,
  output logic                  tx_o,
  output logic                  busy_o
);
  import uart_pkg::*;

  localparam int BCW = 4;

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx: CLKS_PER_BIT must be >= 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end
  if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_dw
    $error("uart_tx: DATA_WIDTH must be 5..9");
  end

  tx_state_e             state, state_n;
  logic [DATA_WIDTH-1:0] shreg, shreg_n;
  logic [BCW-1:0]        bit_cnt, bit_cnt_n;
  logic                  par_bit, par_bit_n;
  logic                  tx_n;
  logic                  bit_done;

  // Every non-idle transition lands on a bit_done wrap, so holding the
  // divider clear in IDLE is enough to align each frame's first bit.
  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (state == IDLE),
    .bit_done (bit_done)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      tx_o    <= 1'b1;
      shreg   <= '0;
      bit_cnt <= '0;
      par_bit <= 1'b0;
    end else begin
      state   <= state_n;
      tx_o    <= tx_n;
      shreg   <= shreg_n;
      bit_cnt <= bit_cnt_n;
      par_bit <= par_bit_n;
    end
  end

  always_comb begin
    state_n   = state;
    tx_n      = tx_o;
    shreg_n   = shreg;
    bit_cnt_n = bit_cnt;
    par_bit_n = par_bit;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (in_valid_i) begin
          state_n   = START;
          tx_n      = 1'b0;
          shreg_n   = in_data_i;
          bit_cnt_n = '0;
          par_bit_n = (^in_data_i) ^ (PARITY_ODD != 0);
        end
      end
      START: begin
        if (bit_done) begin
          state_n   = DATA;
          tx_n      = shreg[0];
          shreg_n   = shreg >> 1;
          bit_cnt_n = '0;
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bit_cnt == BCW'(DATA_WIDTH - 1)) begin
            bit_cnt_n = '0;
            if (PARITY_EN != 0) begin
              state_n = PARITY;
              tx_n    = par_bit;
            end else begin
              state_n = STOP;
              tx_n    = 1'b1;
            end
          end else begin
            bit_cnt_n = bit_cnt + BCW'(1);
            tx_n      = shreg[0];
            shreg_n   = shreg >> 1;
          end
        end
      end
      PARITY: begin
        if (bit_done) begin
          state_n   = STOP;
          tx_n      = 1'b1;
          bit_cnt_n = '0;
        end
      end
      STOP: begin
        if (bit_done) begin
          if (bit_cnt == BCW'(STOP_BITS - 1)) begin
            state_n   = IDLE;
            bit_cnt_n = '0;
          end else begin
            bit_cnt_n = bit_cnt + BCW'(1);
          end
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

  assign in_grant_o = (state == IDLE);
  assign busy_o     = (state != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four configurations side by side plus a line receiver on instance 0.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int CPB = 4;
  localparam int PEN [4] = '{0, 1, 1, 0};
  localparam int POD [4] = '{0, 0, 1, 0};
  localparam int STB [4] = '{1, 1, 1, 2};

  logic            clk = 1'b0;
  logic            reset_n;
  logic [3:0]      vld;
  logic [3:0][7:0] dat;
  logic [3:0]      gnt, txl, bsy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
    .clk(clk), .reset_n(reset_n), .in_valid_i(vld[0]), .in_data_i(dat[0]),
    .in_grant_o(gnt[0]), .tx_o(txl[0]), .busy_o(bsy[0]));
  uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (
    .clk(clk), .reset_n(reset_n), .in_valid_i(vld[1]), .in_data_i(dat[1]),
    .in_grant_o(gnt[1]), .tx_o(txl[1]), .busy_o(bsy[1]));
  uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
    .clk(clk), .reset_n(reset_n), .in_valid_i(vld[2]), .in_data_i(dat[2]),
    .in_grant_o(gnt[2]), .tx_o(txl[2]), .busy_o(bsy[2]));
  uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u3 (
    .clk(clk), .reset_n(reset_n), .in_valid_i(vld[3]), .in_data_i(dat[3]),
    .in_grant_o(gnt[3]), .tx_o(txl[3]), .busy_o(bsy[3]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected line level at cycle k after the handshake edge (k = 1 is the first start-bit cycle).
  function automatic logic exp_tx(input int i, input logic [7:0] w, input int k);
    if (k <= CPB) return 1'b0;
    if (k <= 9 * CPB) return w[(k - CPB - 1) / CPB];
    if (PEN[i] != 0 && k <= 10 * CPB) return (^w) ^ (POD[i] != 0);
    return 1'b1;
  endfunction

  // Mid-bit sampling receiver on instance 0's line.
  logic       rx_act;
  int         rx_cnt;
  logic [7:0] rx_sh;
  int         rx_ferr;
  logic [7:0] rx_q [$];

  always @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_act <= 1'b0;
      rx_cnt <= 0;
    end else if (!rx_act) begin
      if (!txl[0]) begin
        rx_act <= 1'b1;
        rx_cnt <= 1;
      end
    end else begin
      if (rx_cnt % CPB == 2 && rx_cnt >= CPB + 2 && rx_cnt <= 8 * CPB + 2)
        rx_sh[rx_cnt / CPB - 1] <= txl[0];
      if (rx_cnt == 9 * CPB + 2) begin
        rx_q.push_back(rx_sh);
        if (!txl[0]) rx_ferr <= rx_ferr + 1;
        rx_act <= 1'b0;
      end
      rx_cnt <= rx_cnt + 1;
    end
  end

  task automatic run_frames(input logic [3:0][7:0] w);
    int f;
    @(negedge clk);
    for (int i = 0; i < 4; i++) chk($sformatf("i%0d_pre_gnt", i), gnt[i], 1);
    vld = 4'hF;
    dat = w;
    @(posedge clk);
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (k == 1) vld = '0;
      for (int i = 0; i < 4; i++) begin
        f = frame_cycles(8, CPB, PEN[i], STB[i]);
        if (k <= f) begin
          chk($sformatf("i%0d_c%0d_tx", i, k), txl[i], exp_tx(i, w[i], k));
          chk($sformatf("i%0d_c%0d_gnt", i, k), gnt[i], 0);
        end else if (k == f + 1) begin
          chk($sformatf("i%0d_c%0d_gnt_end", i, k), gnt[i], 1);
          chk($sformatf("i%0d_c%0d_busy_end", i, k), bsy[i], 0);
          chk($sformatf("i%0d_c%0d_tx_idle", i, k), txl[i], 1);
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lows, acc, cyc;
    logic [7:0] exp_q [$];
    rx_ferr = 0;
    reset_n = 1'b0;
    vld = '0;
    dat = '0;

    // Reset values
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_i%0d_tx", i), txl[i], 1);
      chk($sformatf("rst_i%0d_gnt", i), gnt[i], 1);
      chk($sformatf("rst_i%0d_busy", i), bsy[i], 0);
    end
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rst_idle_tx", txl[0], 1);
    chk("rst_idle_gnt", gnt[0], 1);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rel_idle_gnt", gnt[0], 1);
    chk("rel_idle_busy", bsy[0], 0);

    // Reset in the middle of DATA: line must go high at once and stay high
    vld[0] = 1'b1;
    dat[0] = 8'h00;
    @(posedge clk);
    @(negedge clk);
    vld[0] = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_data_low", txl[0], 0);
    chk("mid_data_busy", bsy[0], 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_tx", txl[0], 1);
    chk("async_rst_busy", bsy[0], 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_gnt", gnt[0], 1);
    lows = 0;
    repeat (50) begin
      @(negedge clk);
      if (!txl[0]) lows++;
    end
    chk("no_stray_low", lows, 0);
    chk("no_stray_frame", rx_q.size(), 0);

    // Directed frames: 0xA5 plain, 0x07 even/odd parity, 0x3C two stop bits
    run_frames({8'h3C, 8'h07, 8'h07, 8'hA5});
    chk("a5_rx_cnt", rx_q.size(), 1);
    if (rx_q.size() == 1) chk("a5_rx_val", rx_q[0], 8'hA5);
    repeat (3) @(negedge clk);

    // Back-to-back with valid held high
    rx_q.delete();
    vld[0] = 1'b1;
    dat[0] = 8'h00;
    @(posedge clk);
    for (int k = 1; k <= 42; k++) begin
      @(negedge clk);
      if (k == 1) dat[0] = 8'hFF;
      if (k == 40) chk("b2b_gnt_c40", gnt[0], 0);
      if (k == 41) chk("b2b_gnt_c41", gnt[0], 1);
      if (k == 41) chk("b2b_idle_c41", txl[0], 1);
      if (k == 42) begin
        chk("b2b_start_c42", txl[0], 0);
        chk("b2b_gnt_c42", gnt[0], 0);
        vld[0] = 1'b0;
      end
    end
    repeat (45) @(negedge clk);
    chk("b2b_rx_cnt", rx_q.size(), 2);
    if (rx_q.size() == 2) begin
      chk("b2b_rx0", rx_q[0], 8'h00);
      chk("b2b_rx1", rx_q[1], 8'hFF);
    end

    // Random words, random valid gaps, data churn while busy
    rx_q.delete();
    acc = 0;
    cyc = 0;
    while (acc < 20 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      vld[0] = ($urandom_range(0, 2) != 0);
      dat[0] = 8'($urandom);
      if (vld[0] && gnt[0]) begin
        exp_q.push_back(dat[0]);
        acc++;
      end
    end
    @(negedge clk);
    vld[0] = 1'b0;
    chk("rnd_accepted", acc, 20);
    cyc = 0;
    while (bsy[0] && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("rnd_drain_timeout", bsy[0], 0);
    repeat (5) @(negedge clk);
    chk("rnd_rx_cnt", rx_q.size(), exp_q.size());
    for (int j = 0; j < exp_q.size() && j < rx_q.size(); j++)
      chk($sformatf("rnd_rx%0d", j), rx_q[j], exp_q[j]);
    chk("rx_framing", rx_ferr, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial transmitter that sits directly downstream of the FIFO.
- Consumes words through a valid/grant pop-style handshake and serialises each word as an asynchronous UART frame on a single line: start bit, data LSB-first, optional parity, stop bit(s).
- Fixed integer clocks-per-bit timing; no fractional baud.

Parameters:
DATA_WIDTH, 8, payload bits per frame (5..9)
CLKS_PER_BIT, 16, clock cycles per serial bit (>= 2)
PARITY_EN, 0, 1 inserts a parity bit after the data bits
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN = 0)
STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
clk  input  1  single clock; all logic on its rising edge
reset_n  input  1  asynchronous, active-low reset
in_valid_i  input  1  upstream has a word available
in_data_i  input  DATA_WIDTH  word offered by upstream
in_grant_o  output  1  block accepts the word this cycle
tx_o  output  1  serial line, idle high
busy_o  output  1  frame in progress

Behaviour:
- Clock and reset (already decided): one clock, clk; reset_n is asynchronous and active-low.
- Reset values: tx_o = 1, in_grant_o = 1, busy_o = 0, state = IDLE, all counters = 0.
- A reset assertion forces tx_o high immediately (asynchronously). An in-flight word is discarded; no partial frame resumes after reset.
- States: IDLE, START, DATA, PARITY, STOP.
- in_grant_o = (state == IDLE). It is combinational from the state register only, with no path from in_valid_i.
- busy_o = !IDLE. tx_o is registered.
- Transfer: occurs when in_valid_i & in_grant_o at a rising edge (cycle N).
  - in_data_i is captured into the shift register at that edge.
  - The parity bit is computed from the captured word: XOR of the data, inverted if PARITY_ODD.
  - Next state is START.
- START: tx_o = 0 for exactly CLKS_PER_BIT cycles, starting at cycle N+1.
- DATA: DATA_WIDTH bits, LSB first, each held CLKS_PER_BIT cycles. The bit index counter runs 0..DATA_WIDTH-1.
- PARITY: entered only if PARITY_EN; one bit time.
- STOP: tx_o = 1 for STOP_BITS*CLKS_PER_BIT cycles.
- End of frame:
  - Frame length F = CLKS_PER_BIT*(1 + DATA_WIDTH + PARITY_EN + STOP_BITS); the frame occupies cycles N+1..N+F.
  - State returns to IDLE at cycle N+F+1, and in_grant_o rises that cycle.
  - Back-to-back words therefore have exactly one extra idle-high cycle between frames.
- Baud counter:
  - Width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
  - Cleared on every state transition.
  - No off-by-one: every bit time, including the last stop bit, is exactly CLKS_PER_BIT cycles.
- in_valid_i and in_data_i are ignored outside IDLE. Upstream may change or drop them freely while busy.
- in_valid_i held high continuously: one word accepted per frame, no loss, no duplication.
- Elaboration-time assertions: CLKS_PER_BIT >= 2, STOP_BITS in {1,2}, DATA_WIDTH in 5..9.

Decomposition:
- Package uart_pkg holds:
  - typedef enum tx_state_e {IDLE, START, DATA, PARITY, STOP}
  - parity-mode constants (PARITY_EVEN = 0, PARITY_ODD = 1)
  - a frame-length function frame_cycles(dw, cpb, par, stop) shared with the bench and a future uart_rx
- One sub-module is natural: uart_baud_gen, a CLKS_PER_BIT divider with synchronous clear, emitting a one-cycle bit_done pulse when count == CLKS_PER_BIT-1.
- The FSM, shift register and bit counter stay in uart_tx.

Test Plan:
1. Reset asserted mid-idle, then released → tx_o = 1, in_grant_o = 1, busy_o = 0; reset asserted during DATA → tx_o = 1 in the same cycle, grant = 1 after release, no stray low bits.
2. CLKS_PER_BIT = 4, no parity, STOP_BITS = 1; push 0xA5 at cycle 0 → tx_o low cycles 1-4; bits 1,0,1,0,0,1,0,1 over cycles 5-36; high cycles 37-40; in_grant_o low cycles 1-40, high at 41.
3. Same config, in_valid_i held high with 0x00 then 0xFF → second handshake at cycle 41, second start bit at cycle 42; exactly two frames, decoded by a bench receiver model as 0x00, 0xFF.
4. PARITY_EN = 1, PARITY_ODD = 0, push 0x07 → parity bit = 1 on cycles 37-40, stop 41-44, grant at 45; with PARITY_ODD = 1 → parity bit = 0.
5. STOP_BITS = 2, no parity, push 0x3C → tx_o high cycles 37-44, grant at 45.
6. Random words, random in_valid_i gaps and data changes while busy → bench receiver output equals the accepted-word sequence exactly, in order; in_data_i changes while busy have no effect on tx_o.
